// File: rtl/bmp_stream_reader_pkg.sv
// ============================================================================
// Module : bmp_stream_pkg
// Brief  : Shared constants and FSM encoding for the BMP stream reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bmp_stream_pkg;

   localparam logic [7:0] BMP_MAGIC0 = 8'h42;
   localparam logic [7:0] BMP_MAGIC1 = 8'h4D;

   localparam int FSIZE_LSB_IDX = 2;
   localparam int FSIZE_MSB_IDX = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bmp_stream_reader_if.sv
// ============================================================================
// Module : bmp_stream_reader_if
// Brief  : Memory read port and valid/ready byte stream of the BMP reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bmp_stream_reader_if #(
   parameter int ADDR_W = 16
) ();

   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data;
   logic              out_ready;
   logic [7:0]        point_data_out;
   logic              data_valid;
   logic              image_process_start;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rd_data,
      input  out_ready,
      output point_data_out,
      output data_valid,
      output image_process_start
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rd_data,
      output out_ready,
      input  point_data_out,
      input  data_valid,
      input  image_process_start
   );

endinterface

`default_nettype wire

// File: rtl/bmp_stream_reader_byte_skid_fifo.sv
// ============================================================================
// Module : byte_skid_fifo
// Brief  : 2-deep, 9-bit ({flag,byte}) FIFO decoupling memory reads from the
//          stream handshake. Simultaneous write and read are allowed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_skid_fifo (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       wr_en,
   input  wire logic [8:0] wr_data,
   input  wire logic       rd_en,
   output logic [8:0]      rd_data,
   output logic [1:0]      count,
   output logic            empty
);

   logic [8:0] mem_q [2];
   logic [8:0] mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (rd_en) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, wr_en} - {1'b0, rd_en};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign empty   = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/bmp_stream_reader.sv
// ============================================================================
// Module : bmp_stream_reader
// Brief  : Reads a BMP file image from byte memory and streams it out,
//          flagging pixel bytes and checking magic/file size on the fly.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bmp_stream_reader
   import bmp_stream_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int HEADER_BYTES = 54,
   parameter int MAX_BYTES    = 65535
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   input  wire logic           start,
   output logic                busy,
   output logic                frame_done,
   output logic                hdr_err,
   bmp_stream_reader_if.master bus
);

   // One spare bit so the read address can step past the last byte.
   localparam int            CW       = ADDR_W + 1;
   localparam logic [CW-1:0] LAST_MAX = CW'(MAX_BYTES - 1);
   localparam logic [CW-1:0] HDR_IDX  = CW'(HEADER_BYTES);

   state_t        state_q, state_d;
   logic [CW-1:0] rd_addr_q, rd_addr_d;
   logic [CW-1:0] last_addr_q, last_addr_d;
   logic [CW-1:0] out_idx_q, out_idx_d;
   logic [CW-1:0] ret_addr_q, ret_addr_d;
   logic          inflight_q, inflight_d;
   logic [23:0]   fsize_lo_q, fsize_lo_d;
   logic          hdr_err_q, hdr_err_d;

   logic [8:0]  fifo_rd_data;
   logic [1:0]  fifo_count;
   logic        fifo_empty;
   logic        pop;
   logic        issue;
   logic [2:0]  occ;
   logic [31:0] fsize_full;

   assign pop = !fifo_empty && bus.out_ready;

   // Counting the byte leaving this cycle keeps the pipe full with no bubbles.
   assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = (state_q == READ) && (occ < 3'd2) && (rd_addr_q <= last_addr_q);

   assign fsize_full = {bus.mem_rd_data, fsize_lo_q};

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      last_addr_d = last_addr_q;
      out_idx_d   = out_idx_q;
      ret_addr_d  = ret_addr_q;
      inflight_d  = issue;
      fsize_lo_d  = fsize_lo_q;
      hdr_err_d   = hdr_err_q;

      if (issue) begin
         rd_addr_d  = rd_addr_q + CW'(1);
         ret_addr_d = rd_addr_q;
      end
      if (pop) begin
         out_idx_d = out_idx_q + CW'(1);
      end

      if (inflight_q) begin
         if (ret_addr_q == CW'(0) && bus.mem_rd_data != BMP_MAGIC0) hdr_err_d = 1'b1;
         if (ret_addr_q == CW'(1) && bus.mem_rd_data != BMP_MAGIC1) hdr_err_d = 1'b1;
         if (ret_addr_q == CW'(FSIZE_LSB_IDX))     fsize_lo_d[7:0]   = bus.mem_rd_data;
         if (ret_addr_q == CW'(FSIZE_LSB_IDX + 1)) fsize_lo_d[15:8]  = bus.mem_rd_data;
         if (ret_addr_q == CW'(FSIZE_LSB_IDX + 2)) fsize_lo_d[23:16] = bus.mem_rd_data;
         if (ret_addr_q == CW'(FSIZE_MSB_IDX)) begin
            if (fsize_full < 32'(HEADER_BYTES + 1) || fsize_full > 32'(MAX_BYTES)) begin
               hdr_err_d   = 1'b1;
               last_addr_d = LAST_MAX;
            end else begin
               last_addr_d = CW'(fsize_full - 32'd1);
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = READ;
               rd_addr_d   = '0;
               out_idx_d   = '0;
               hdr_err_d   = 1'b0;
               last_addr_d = LAST_MAX;
            end
         end
         READ: begin
            if (issue && rd_addr_q == last_addr_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && out_idx_q == last_addr_q) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         last_addr_q <= '0;
         out_idx_q   <= '0;
         ret_addr_q  <= '0;
         inflight_q  <= 1'b0;
         fsize_lo_q  <= '0;
         hdr_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         last_addr_q <= last_addr_d;
         out_idx_q   <= out_idx_d;
         ret_addr_q  <= ret_addr_d;
         inflight_q  <= inflight_d;
         fsize_lo_q  <= fsize_lo_d;
         hdr_err_q   <= hdr_err_d;
      end
   end

   // Bytes return in address order, so the return address is the out index.
   byte_skid_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (inflight_q),
      .wr_data ({(ret_addr_q >= HDR_IDX), bus.mem_rd_data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   assign bus.mem_rd_en           = issue;
   assign bus.mem_addr            = rd_addr_q[ADDR_W-1:0];
   assign bus.point_data_out      = fifo_rd_data[7:0];
   assign bus.image_process_start = fifo_rd_data[8];
   assign bus.data_valid          = !fifo_empty;

   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
   assign hdr_err    = hdr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bmp_stream_reader.sv
// ============================================================================
// Module : tb_bmp_stream_reader
// Brief  : Randomized self-checking bench for bmp_stream_reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bmp_stream_reader;

   localparam int HB   = 54;
   localparam int MAXB = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, frame_done, hdr_err;

   bmp_stream_reader_if #(.ADDR_W(16)) bus ();

   bmp_stream_reader #(
      .ADDR_W       (16),
      .HEADER_BYTES (HB),
      .MAX_BYTES    (MAXB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .hdr_err    (hdr_err),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:255];

   // Read data valid exactly one cycle after the strobe; garbage otherwise.
   always @(posedge clk) begin
      bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr[7:0]] : 8'($urandom);
   end

   int n_checks = 0;
   int n_errors = 0;

   int exp_n;
   bit exp_err;
   bit exp_magic_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: fill memory with a file image and derive the expected frame.
   task automatic load_file(input logic [7:0] magic1, input int fsize);
      logic [31:0] fs;
      bit          bad_size;
      fs = 32'(fsize);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h42;
      mem[1] = magic1;
      mem[2] = fs[7:0];
      mem[3] = fs[15:8];
      mem[4] = fs[23:16];
      mem[5] = fs[31:24];
      bad_size      = (fsize < HB + 1) || (fsize > MAXB);
      exp_magic_err = (magic1 != 8'h4D);
      exp_err       = exp_magic_err || bad_size;
      exp_n         = bad_size ? MAXB : fsize;
   endtask

   function automatic logic ready_for(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 2) == 1;
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq(tag, {busy, frame_done, hdr_err, bus.data_valid, bus.mem_rd_en,
                     bus.image_process_start, bus.point_data_out, bus.mem_addr}, 32'd0);
   endtask

   task automatic run_frame(input int mode, input int rst_after, input int restart_cyc);
      int         cyc, rd_cnt, xf, first_v, done_cyc;
      bit         done, prev_stall;
      logic [8:0] prev;
      cyc = 0; rd_cnt = 0; xf = 0; first_v = -1; done_cyc = -1;
      done = 1'b0; prev_stall = 1'b0; prev = '0;
      @(posedge clk);
      #1 start = 1'b1;
      bus.out_ready = 1'b1;
      while (!done && cyc < 2000) begin
         @(posedge clk);
         cyc++;
         #1;
         start         = (cyc == restart_cyc);
         bus.out_ready = ready_for(mode, cyc);
         #4;
         if (bus.mem_rd_en) begin
            check_eq("rd_addr", 32'(bus.mem_addr), 32'(rd_cnt));
            rd_cnt++;
         end
         check_eq("rd_within_frame", 32'(rd_cnt <= exp_n), 32'd1);
         if (prev_stall)
            check_eq("stall_hold", {bus.data_valid, bus.image_process_start, bus.point_data_out},
                     {1'b1, prev});
         if (bus.data_valid && first_v < 0) first_v = cyc;
         if (bus.data_valid && bus.out_ready) begin
            check_eq("byte", 32'(bus.point_data_out), 32'(mem[xf]));
            check_eq("pixel_flag", 32'(bus.image_process_start), 32'(xf >= HB));
            xf++;
         end
         check_eq("outstanding_le2", 32'((rd_cnt - xf) <= 2), 32'd1);
         prev_stall = bus.data_valid && !bus.out_ready;
         prev       = {bus.image_process_start, bus.point_data_out};
         if (cyc == 1) check_eq("hdr_err_cleared", 32'(hdr_err), 32'd0);
         if (cyc == 4) check_eq("hdr_err_magic", 32'(hdr_err), 32'(exp_magic_err));
         if (frame_done) begin
            done     = 1'b1;
            done_cyc = cyc;
         end
         if (rst_after >= 0 && xf == rst_after) begin
            rst_n = 1'b0;
            #1 check_all_zero("reset_mid_frame");
            repeat (2) @(posedge clk);
            #1 check_all_zero("reset_hold");
            rst_n = 1'b1;
            return;
         end
      end
      check_eq("frame_done_seen", 32'(done), 32'd1);
      check_eq("xfer_count", 32'(xf), 32'(exp_n));
      check_eq("read_count", 32'(rd_cnt), 32'(exp_n));
      check_eq("hdr_err_end", 32'(hdr_err), 32'(exp_err));
      check_eq("first_valid_cycle", 32'(first_v), 32'd3);
      if (mode == 0) check_eq("frame_done_cycle", 32'(done_cyc), 32'(exp_n + 3));
      @(posedge clk);
      #1 check_eq("idle_after_done", {30'd0, busy, frame_done}, 32'd0);
   endtask

   initial begin
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset_state");
      rst_n = 1'b1;

      load_file(8'h4D, 64);  run_frame(0, -1, 0);
      run_frame(1, -1, 0);
      load_file(8'h00, 64);  run_frame(0, -1, 0);
      load_file(8'h4D, 40);  run_frame(0, -1, 0);
      load_file(8'h4D, 64);  run_frame(0, 20, 0);
      run_frame(0, -1, 0);
      run_frame(0, -1, 30);

      for (int t = 0; t < 8; t++) begin
         load_file(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h4D,
                   int'($urandom_range(40, 130)));
         run_frame(2, -1, ($urandom_range(0, 1) == 1) ? 20 : 0);
      end
      load_file(8'h4D, HB + 1);  run_frame(0, -1, 0);
      load_file(8'h4D, MAXB);    run_frame(2, -1, 0);
      load_file(8'h4D, MAXB + 1); run_frame(1, -1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
